// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I control path: FSM state codes,
// base opcodes, datapath mux/ALU encodings and the one-hot instruction class.
package mc_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
    localparam logic [1:0] PC_SEL_IMM   = 2'b01;
    localparam logic [1:0] PC_SEL_JALR  = 2'b10;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_CMP   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    typedef struct packed {
        logic op;
        logic op_imm;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
        logic system;
    } opclass_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory handshake between the control FSM (master) and
// the memory subsystem (slave).
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (output imem_req, dmem_req, dmem_we, input imem_ready, dmem_ready);
    modport slave  (input imem_req, dmem_req, dmem_we, output imem_ready, dmem_ready);
endinterface

// File: rtl/mc_opclass.sv
// Combinational RV32I opcode classifier: one-hot class plus a valid bit
// that is low for any opcode outside the supported base set.
module mc_opclass
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   cls,
    output logic       valid
);

    always_comb begin
        cls = '0;
        case (opcode)
            OPC_OP:     cls.op     = 1'b1;
            OPC_OP_IMM: cls.op_imm = 1'b1;
            OPC_LOAD:   cls.load   = 1'b1;
            OPC_STORE:  cls.store  = 1'b1;
            OPC_BRANCH: cls.branch = 1'b1;
            OPC_JAL:    cls.jal    = 1'b1;
            OPC_JALR:   cls.jalr   = 1'b1;
            OPC_LUI:    cls.lui    = 1'b1;
            OPC_AUIPC:  cls.auipc  = 1'b1;
            OPC_SYSTEM: cls.system = 1'b1;
            default:    cls        = '0;
        endcase
        valid = |cls;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core with memory watchdog and
// retire counter. Define MC_ILLEGAL_TRAP_EN to halt on unknown opcodes.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                branch_taken,
    multicycle_ctrl_if.master   mem,
    output logic                ir_we,
    output logic                pc_we,
    output logic                reg_we,
    output logic [1:0]          pc_sel,
    output logic [1:0]          wb_sel,
    output logic                alu_src_b,
    output logic [1:0]          alu_op,
    output logic                halted,
    output logic                bus_err,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [2:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              halted_q, bus_err_q;
    logic [CNT_W-1:0]  count_q;
    logic              imem_req, dmem_req, dmem_we;
    logic              waiting, timeout_hit;
    opclass_t          cls;
    logic              cls_valid;
`ifdef MC_ILLEGAL_TRAP_EN
    logic              illegal_q, illegal_trap;
`endif

    // funct3 is decoded by the ALU control downstream, not by this FSM
    logic unused_funct3;
    assign unused_funct3 = ^funct3;

    mc_opclass u_opclass (
        .opcode (opcode),
        .cls    (cls),
        .valid  (cls_valid)
    );

    assign waiting = ((state_q == ST_FETCH) && !mem.imem_ready) ||
                     ((state_q == ST_MEM)   && !mem.dmem_ready);
    assign timeout_hit = waiting && (TIMEOUT_CYCLES != 0) &&
                         (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        pc_sel    = PC_SEL_PLUS4;
        wb_sel    = WB_SEL_ALU;
        alu_src_b = 1'b0;
        alu_op    = ALU_OP_ADD;
`ifdef MC_ILLEGAL_TRAP_EN
        illegal_trap = 1'b0;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (mem.imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (timeout_hit) begin
                    state_d = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (cls.system) state_d = ST_HALT;
`ifdef MC_ILLEGAL_TRAP_EN
                else if (!cls_valid) begin
                    state_d      = ST_HALT;
                    illegal_trap = 1'b1;
                end
`endif
                else state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (cls.op || cls.op_imm) begin
                    alu_op    = ALU_OP_FUNCT;
                    alu_src_b = cls.op_imm;
                    state_d   = ST_WB;
                end else if (cls.lui || cls.auipc) begin
                    state_d = ST_WB;
                end else if (cls.load || cls.store) begin
                    alu_op    = ALU_OP_ADD;
                    alu_src_b = 1'b1;
                    state_d   = ST_MEM;
                end else if (cls.branch) begin
                    alu_op  = ALU_OP_CMP;
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
                    state_d = ST_FETCH;
                end else if (cls.jal || cls.jalr) begin
                    reg_we    = 1'b1;
                    wb_sel    = WB_SEL_PC4;
                    pc_we     = 1'b1;
                    pc_sel    = cls.jal ? PC_SEL_IMM : PC_SEL_JALR;
                    alu_src_b = cls.jalr;
                    state_d   = ST_FETCH;
                end else begin
                    // unknown opcode retires as a NOP
                    pc_we   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cls.store;
                if (mem.dmem_ready) begin
                    if (cls.store) begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_HALT;
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                wb_sel  = cls.load ? WB_SEL_MEM : WB_SEL_ALU;
                pc_we   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // The wait counter restarts on every state change, so it only ever
    // measures the current FETCH or MEM handshake.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q)
            wait_d = '0;
        else if (waiting && (TIMEOUT_CYCLES != 0))
            wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            halted_q  <= halted_q | (state_d == ST_HALT);
            bus_err_q <= bus_err_q | timeout_hit;
            if (pc_we)
                count_q <= count_q + CNT_W'(1);
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) illegal_q <= 1'b0;
        else        illegal_q <= illegal_q | illegal_trap;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign mem.imem_req = imem_req;
    assign mem.dmem_req = dmem_req;
    assign mem.dmem_we  = dmem_we;
    assign halted       = halted_q;
    assign bus_err      = bus_err_q;
    assign instr_count  = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction timing per class, memory
// wait states, watchdog timeout, halt, unknown opcode and mid-access reset.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        branch_taken = 1'b0;
    logic        ir_we, pc_we, reg_we, alu_src_b, halted, bus_err, illegal;
    logic [1:0]  pc_sel, wb_sel, alu_op;
    logic [31:0] instr_count;

    multicycle_ctrl_if mem();

    multicycle_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct3       (funct3),
        .branch_taken (branch_taken),
        .mem          (mem),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .reg_we       (reg_we),
        .pc_sel       (pc_sel),
        .wb_sel       (wb_sel),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .halted       (halted),
        .bus_err      (bus_err),
        .illegal      (illegal),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // land 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [6:0] op;
        int         iw;
        int         dw;
        logic       tk;
        int         cyc;
        logic [1:0] psel;
        int         rcyc;
        logic [1:0] wsel;
        int         dreq;
        logic       dwe;
        logic [2:0] alu;
    } vec_t;

    vec_t vecs[10];

    int         r_cyc, r_irw, r_dreq, r_rcyc;
    logic [1:0] r_psel, r_wsel;
    logic       r_dwe, r_done;
    logic [2:0] r_alu;

    // Runs one instruction from its first FETCH cycle until pc_we or halt,
    // acting as a memory with iw/dw wait cycles before ready.
    task automatic exec(input logic [6:0] op, input int iw, input int dw, input logic tk);
        int fw;
        int dwc;
        fw = 0; dwc = 0;
        r_cyc = 0; r_irw = 0; r_dreq = 0; r_rcyc = 0;
        r_psel = 2'b11; r_wsel = 2'b00; r_dwe = 1'b0; r_done = 1'b0; r_alu = 3'b000;
        opcode = op;
        branch_taken = tk;
        while (!r_done && r_cyc < 40) begin
            r_cyc++;
            mem.imem_ready = mem.imem_req && (fw == iw);
            mem.dmem_ready = mem.dmem_req && (dwc == dw);
            #1;
            if (mem.imem_req) fw++;
            if (mem.dmem_req) begin
                r_dreq++;
                dwc++;
                r_dwe = r_dwe | mem.dmem_we;
            end
            if (ir_we) r_irw++;
            if (r_cyc == iw + 3) r_alu = {alu_op, alu_src_b};
            if (reg_we) begin
                r_rcyc = r_cyc;
                r_wsel = wb_sel;
            end
            if (pc_we) begin
                r_psel = pc_sel;
                r_done = 1'b1;
            end
            if (halted) r_done = 1'b1;
            cyc();
        end
        mem.imem_ready = 1'b0;
        mem.dmem_ready = 1'b0;
        check("exec_bound", {31'b0, r_done}, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        opcode = '0;
        branch_taken = 1'b0;
        mem.imem_ready = 1'b0;
        mem.dmem_ready = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        #1;
        check("rst_imem_req", {31'b0, mem.imem_req}, 0);
        check("rst_strobes", {29'b0, ir_we, pc_we, reg_we}, 0);
        check("rst_flags", {29'b0, halted, bus_err, illegal}, 0);
        check("rst_count", instr_count, 0);
        cyc();
    endtask

    initial begin
        vecs[0] = '{7'b0010011, 0, 0, 1'b0, 4, 2'b00, 4, 2'b00, 0, 1'b0, 3'b101}; // addi
        vecs[1] = '{7'b0000011, 0, 3, 1'b0, 8, 2'b00, 8, 2'b01, 4, 1'b0, 3'b001}; // lw, 3 waits
        vecs[2] = '{7'b1100011, 0, 0, 1'b1, 3, 2'b01, 0, 2'b00, 0, 1'b0, 3'b010}; // beq taken
        vecs[3] = '{7'b1100011, 0, 0, 1'b0, 3, 2'b00, 0, 2'b00, 0, 1'b0, 3'b010}; // beq not taken
        vecs[4] = '{7'b1101111, 2, 0, 1'b0, 5, 2'b01, 5, 2'b10, 0, 1'b0, 3'b000}; // jal, 2 fetch waits
        vecs[5] = '{7'b1100111, 0, 0, 1'b0, 3, 2'b10, 3, 2'b10, 0, 1'b0, 3'b001}; // jalr
        vecs[6] = '{7'b0100011, 0, 1, 1'b0, 5, 2'b00, 0, 2'b00, 2, 1'b1, 3'b001}; // sw, 1 wait
        vecs[7] = '{7'b0110011, 0, 0, 1'b0, 4, 2'b00, 4, 2'b00, 0, 1'b0, 3'b100}; // add
        vecs[8] = '{7'b0110111, 0, 0, 1'b0, 4, 2'b00, 4, 2'b00, 0, 1'b0, 3'b000}; // lui
        vecs[9] = '{7'b0010011, 3, 0, 1'b0, 7, 2'b00, 7, 2'b00, 0, 1'b0, 3'b101}; // addi, ready at timeout

        mem.imem_ready = 1'b0;
        mem.dmem_ready = 1'b0;
        #2;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            exec(vecs[i].op, vecs[i].iw, vecs[i].dw, vecs[i].tk);
            check($sformatf("v%0d_cycles", i), r_cyc, vecs[i].cyc);
            check($sformatf("v%0d_ir_we", i), r_irw, 1);
            check($sformatf("v%0d_dmem_req", i), r_dreq, vecs[i].dreq);
            check($sformatf("v%0d_dmem_we", i), {31'b0, r_dwe}, {31'b0, vecs[i].dwe});
            check($sformatf("v%0d_pc_sel", i), {30'b0, r_psel}, {30'b0, vecs[i].psel});
            check($sformatf("v%0d_reg_we_cyc", i), r_rcyc, vecs[i].rcyc);
            check($sformatf("v%0d_wb_sel", i), {30'b0, r_wsel}, {30'b0, vecs[i].wsel});
            check($sformatf("v%0d_alu", i), {29'b0, r_alu}, {29'b0, vecs[i].alu});
            check($sformatf("v%0d_count", i), instr_count, i + 1);
            check($sformatf("v%0d_bus_err", i), {31'b0, bus_err}, 0);
            $display("instr %0d op=%b cycles=%0d pc_sel=%b count=%0d", i, vecs[i].op, r_cyc, r_psel, instr_count);
        end

        exec(7'b1110011, 0, 0, 1'b0);
        check("ecall_cycles", r_cyc, 3);
        check("ecall_halted", {31'b0, halted}, 1);
        check("ecall_bus_err", {31'b0, bus_err}, 0);
        check("ecall_count", instr_count, 10);
        check("halt_sticky", {30'b0, halted, mem.imem_req}, 2);
        $display("instr ecall cycles=%0d halted=%b count=%0d", r_cyc, halted, instr_count);

        do_reset();
        exec(7'b0000000, 0, 0, 1'b0);
`ifdef MC_ILLEGAL_TRAP_EN
        check("ill_cycles", r_cyc, 3);
        check("ill_flags", {30'b0, illegal, halted}, 3);
        check("ill_count", instr_count, 0);
`else
        check("nop_cycles", r_cyc, 3);
        check("nop_pc_sel", {30'b0, r_psel}, 0);
        check("nop_reg_we", r_rcyc, 0);
        check("nop_flags", {30'b0, illegal, halted}, 0);
        check("nop_count", instr_count, 1);
`endif
        $display("instr unknown cycles=%0d illegal=%b count=%0d", r_cyc, illegal, instr_count);

        do_reset();
        exec(7'b0010011, 0, 0, 1'b0);
        check("pre_rst_count", instr_count, 1);
        opcode = 7'b0000011;
        mem.imem_ready = 1'b1;
        cyc();
        mem.imem_ready = 1'b0;
        cyc();
        cyc();
        #1;
        check("mem_req_before_rst", {31'b0, mem.dmem_req}, 1);
        reset = 1'b0;
        #1;
        check("rst_drops_dmem_req", {31'b0, mem.dmem_req}, 0);
        check("rst_no_strobe", {29'b0, ir_we, pc_we, reg_we}, 0);
        check("rst_mid_count", instr_count, 0);
        #1;
        reset = 1'b1;
        #1;
        check("idle_after_rst", {31'b0, mem.imem_req}, 0);
        cyc();
        check("fetch_after_idle", {31'b0, mem.imem_req}, 1);
        $display("instr load reset mid-MEM count=%0d", instr_count);

        exec(7'b0010011, 99, 0, 1'b0);
        check("to_cycles", r_cyc, 5);
        check("to_ir_we", r_irw, 0);
        check("to_bus_err", {31'b0, bus_err}, 1);
        check("to_halted", {31'b0, halted}, 1);
        check("to_count", instr_count, 0);
        $display("instr fetch timeout cycles=%0d bus_err=%b halted=%b", r_cyc, bus_err, halted);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
